mojo_serial_block_out: RTL and testbench
========================================

// Module: mojo_serial_block_out
// PURPOSE
//  Transmit-side twin of the serial block receiver. Accepts a BLOCK_BYTES-wide
//  word in one cycle and feeds it byte-by-byte, most-significant byte first, to
//  the byte-wide serial transmitter (tx_data/new_tx_data/tx_busy handshake).
//  A block sent through the transmitter and received by the block receiver
//  reproduces the original word bit-for-bit.
// PARAMETERS
//  BLOCK_BYTES  1  bytes per block; must be >= 1.
// PORTS
//  clk           in   1                clock, all state on rising edge
//  rst           in   1                reset; asynchronous, active-high
//  tx_block      in   BLOCK_BYTES*8    block to send; byte [top] goes first
//  new_tx_block  in   1                1-cycle strobe; accepted only when !block_busy
//  block_busy    out  1                high from accept until last byte completes
//  block_done    out  1                1-cycle pulse when last byte finishes
//  tx_data       out  8                byte to serial transmitter
//  new_tx_data   out  1                1-cycle strobe to serial transmitter
//  tx_busy       in   1                serial transmitter busy
// BEHAVIOUR
//  - Reset (any time, incl. mid-block): state=IDLE; block_busy, block_done,
//    new_tx_data = 0; tx_data = 8'h00; shift reg and counter cleared. Partially
//    sent block is abandoned, never resumed.
//  - All outputs registered. Byte counter width $clog2(BLOCK_BYTES+1).
//  - FSM: IDLE -> SEND -> GUARD -> WAIT -> (SEND | IDLE).
//    IDLE : new_tx_block=1 at edge E0 -> latch tx_block into shift reg,
//           count=BLOCK_BYTES, block_busy=1 from E0, go SEND.
//    SEND : on edge with tx_busy=0 -> tx_data=shreg[top byte], new_tx_data=1
//           for exactly one cycle, shift reg left 8, count-1, go GUARD.
//           tx_busy=1 -> stay (holds indefinitely, no timeout).
//    GUARD: one cycle unconditional; covers transmitter's 1-cycle busy latency.
//    WAIT : stay while tx_busy=1; on tx_busy=0: count!=0 -> SEND;
//           count==0 -> IDLE, block_busy=0 and block_done=1 same edge.
//  - Minimum first-byte latency: new_tx_data high in cycle after E1 (E0+1).
//  - tx_data held stable from strobe until next strobe (not cleared).
//  - new_tx_block while block_busy=1: ignored, no effect on current block.
//  - new_tx_block in the cycle block_done=1: accepted (block_busy already 0),
//    back-to-back blocks have no idle gap beyond the FSM cycles.
//  - tx_block sampled only at accept edge; later changes have no effect.
//  - BLOCK_BYTES=1: single pass SEND->GUARD->WAIT->IDLE.
// CONFIGURATION
//  SERIAL_BLOCK_OUT_CHECKSUM_EN defined: after the last data byte one extra
//    byte is sent = XOR of all BLOCK_BYTES data bytes, same SEND/GUARD/WAIT
//    handshake; block_done pulses only after the checksum byte completes.
//    Counter initialised to BLOCK_BYTES+1 (width sized accordingly).
//  Not defined: exactly BLOCK_BYTES bytes per block, no checksum logic.
// TESTING
//  1 BLOCK_BYTES=4, tx_block=32'hDEADBEEF, tx_busy model: busy 1 cycle after
//    strobe for 10 cycles -> strobes carry DE,AD,BE,EF in order; 4 strobes;
//    block_done pulses once; block_busy=0 after.
//  2 tx_busy held 1 for 50 cycles at accept -> no new_tx_data during hold;
//    first strobe (DE) one cycle after tx_busy drops.
//  3 new_tx_block=1 with 32'h12345678 while busy on 32'hDEADBEEF -> output
//    stream DE,AD,BE,EF only; second block lost.
//  4 rst asserted after 2nd byte strobe -> outputs 0 immediately (async);
//    new block 32'h01020304 after release -> 01,02,03,04 only.
//  5 new_tx_block asserted in block_done cycle -> accepted; streams concatenate.
//  6 CHECKSUM_EN, BLOCK_BYTES=2, 16'hA55A -> bytes A5,5A,FF; done after FF.
//    Loopback via serial tx/rx + block receiver reproduces tx_block exactly.

Source files
------------

// File: rtl/mojo_serial_block_out.sv
// mojo_serial_block_out
//   Takes a BLOCK_BYTES-wide word in one cycle and hands it, most-significant
//   byte first, to a byte-wide serial transmitter using the
//   tx_data / new_tx_data / tx_busy handshake.
//   Optional feature macro: SERIAL_BLOCK_OUT_CHECKSUM_EN. When it is defined,
//   an XOR checksum byte of the data bytes follows the last data byte.
module mojo_serial_block_out #(
    parameter int BLOCK_BYTES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BLOCK_BYTES*8-1:0] tx_block,
    input  logic                     new_tx_block,
    output logic                     block_busy,
    output logic                     block_done,
    output logic [7:0]               tx_data,
    output logic                     new_tx_data,
    input  logic                     tx_busy
);

`ifdef SERIAL_BLOCK_OUT_CHECKSUM_EN
    // The checksum travels as one extra byte at the bottom of the shift register.
    localparam int N_BYTES = BLOCK_BYTES + 1;
`else
    localparam int N_BYTES = BLOCK_BYTES;
`endif
    localparam int CNT_W = $clog2(N_BYTES + 1);
    localparam int SH_W  = N_BYTES * 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_GUARD = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [SH_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              block_busy_q, block_busy_d;
    logic              block_done_q, block_done_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              new_tx_data_q, new_tx_data_d;
    logic [SH_W-1:0]   load_word;

`ifdef SERIAL_BLOCK_OUT_CHECKSUM_EN
    logic [7:0] csum;

    // XOR of every data byte of the incoming block.
    always_comb begin
        csum = 8'h00;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            csum = csum ^ tx_block[i*8 +: 8];
        end
    end

    assign load_word = {tx_block, csum};
`else
    assign load_word = tx_block;
`endif

    // Next-state and next-output logic for the byte sequencer.
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        count_d       = count_q;
        block_busy_d  = block_busy_q;
        block_done_d  = 1'b0;
        tx_data_d     = tx_data_q;
        new_tx_data_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (new_tx_block) begin
                    shreg_d      = load_word;
                    count_d      = CNT_W'(N_BYTES);
                    block_busy_d = 1'b1;
                    state_d      = S_SEND;
                end
            end
            S_SEND: begin
                // Wait for the transmitter to be free; no timeout.
                if (!tx_busy) begin
                    tx_data_d     = shreg_q[SH_W-1 -: 8];
                    new_tx_data_d = 1'b1;
                    shreg_d       = shreg_q << 8;
                    count_d       = count_q - CNT_W'(1);
                    state_d       = S_GUARD;
                end
            end
            S_GUARD: begin
                // Transmitter raises tx_busy one cycle after the strobe;
                // skip that cycle so WAIT never sees a stale idle.
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!tx_busy) begin
                    if (count_q != '0) begin
                        state_d = S_SEND;
                    end else begin
                        state_d      = S_IDLE;
                        block_busy_d = 1'b0;
                        block_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any partial block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            shreg_q       <= '0;
            count_q       <= '0;
            block_busy_q  <= 1'b0;
            block_done_q  <= 1'b0;
            tx_data_q     <= 8'h00;
            new_tx_data_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            count_q       <= count_d;
            block_busy_q  <= block_busy_d;
            block_done_q  <= block_done_d;
            tx_data_q     <= tx_data_d;
            new_tx_data_q <= new_tx_data_d;
        end
    end

    assign block_busy  = block_busy_q;
    assign block_done  = block_done_q;
    assign tx_data     = tx_data_q;
    assign new_tx_data = new_tx_data_q;

endmodule

// File: tb/tb_mojo_serial_block_out.sv
// Bench for mojo_serial_block_out (BLOCK_BYTES=4). Expected byte stream and
// block-done markers are queued when a block is issued; a monitor pops them
// as the DUT strobes. Honors SERIAL_BLOCK_OUT_CHECKSUM_EN in its model.
module tb_mojo_serial_block_out;
    localparam int NB = 4;
    localparam logic [8:0] DONE_MARK = 9'h100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB*8-1:0] tx_block = '0;
    logic          new_tx_block = 1'b0;
    logic          block_busy, block_done;
    logic [7:0]    tx_data;
    logic          new_tx_data;
    logic          tx_busy;

    logic          hold_busy = 1'b0;
    int            busy_cnt = 0;
    int            bmax = 10;

    int            compared = 0;
    int            mismatched = 0;
    logic [8:0]    exp_q[$];

    assign tx_busy = hold_busy | (busy_cnt != 0);

    mojo_serial_block_out #(.BLOCK_BYTES(NB)) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_block     (tx_block),
        .new_tx_block (new_tx_block),
        .block_busy   (block_busy),
        .block_done   (block_done),
        .tx_data      (tx_data),
        .new_tx_data  (new_tx_data),
        .tx_busy      (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a block is its bytes MSB first, optional XOR byte, then done.
    task automatic push_block(input logic [NB*8-1:0] d);
        logic [7:0] x;
        x = 8'h00;
        for (int i = NB - 1; i >= 0; i--) begin
            exp_q.push_back({1'b0, d[i*8 +: 8]});
            x = x ^ d[i*8 +: 8];
        end
`ifdef SERIAL_BLOCK_OUT_CHECKSUM_EN
        exp_q.push_back({1'b0, x});
`endif
        exp_q.push_back(DONE_MARK);
    endtask

    // Serial transmitter model: busy for 1..bmax cycles after each strobe.
    always begin
        @(posedge clk);
        #1;
        if (rst) busy_cnt = 0;
        else if (new_tx_data) busy_cnt = $urandom_range(1, bmax);
        else if (busy_cnt != 0) busy_cnt = busy_cnt - 1;
    end

    // Monitor: compare every strobe and done pulse against the queue.
    always begin
        logic busy_at_edge;
        logic [8:0] e;
        @(posedge clk);
        busy_at_edge = tx_busy;
        #1;
        if (!rst && new_tx_data) begin
            chk("strobe_while_tx_busy", int'(busy_at_edge), 0);
            if (exp_q.size() == 0) chk("unexpected_strobe", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("tx_data", int'({1'b0, tx_data}), int'(e));
            end
        end
        if (!rst && block_done) begin
            chk("busy_low_at_done", int'(block_busy), 0);
            if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("done_marker", int'({1'b0, block_done} << 8), int'(e));
            end
        end
    end

    task automatic send_now(input logic [NB*8-1:0] d, input bit expect_accept);
        tx_block = d;
        new_tx_block = 1'b1;
        if (expect_accept) push_block(d);
        @(negedge clk);
        new_tx_block = 1'b0;
        tx_block = {$urandom()};  // later changes must not matter
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (block_busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (block_busy) chk({name, "_idle_timeout"}, 1, 0);
    endtask

    task automatic check_drained(input string name);
        repeat (2) @(negedge clk);
        chk({name, "_pending"}, exp_q.size(), 0);
        chk({name, "_busy_after"}, int'(block_busy), 0);
    endtask

    initial begin
        int n;
        logic [NB*8-1:0] d;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(block_busy), 0);
        chk("rst_done", int'(block_done), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_strobe", int'(new_tx_data), 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: basic block
        send_now(32'hDEADBEEF, 1'b1);
        chk("busy_after_accept", int'(block_busy), 1);
        wait_idle("t1");
        check_drained("t1");

        // 2: transmitter held busy at accept
        hold_busy = 1'b1;
        send_now(32'hDEADBEEF, 1'b1);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (new_tx_data) n++;
        end
        chk("t2_strobes_during_hold", n, 0);
        hold_busy = 1'b0;
        @(posedge clk);
        #2;
        chk("t2_first_strobe", int'(new_tx_data), 1);
        chk("t2_first_byte", int'(tx_data), 8'hDE);
        wait_idle("t2");
        check_drained("t2");

        // 3: new block while busy is ignored
        send_now(32'hDEADBEEF, 1'b1);
        repeat (3) @(negedge clk);
        chk("t3_busy", int'(block_busy), 1);
        send_now(32'h12345678, 1'b0);
        wait_idle("t3");
        check_drained("t3");

        // 4: async reset after 2nd strobe, then a fresh block
        send_now(32'hDEADBEEF, 1'b1);
        n = 0;
        for (int i = 0; i < 500 && n < 2; i++) begin
            @(posedge clk);
            #1;
            if (new_tx_data) n++;
        end
        chk("t4_two_strobes", n, 2);
        #1;
        rst = 1'b1;
        #1;
        chk("t4_rst_busy", int'(block_busy), 0);
        chk("t4_rst_tx_data", int'(tx_data), 0);
        chk("t4_rst_strobe", int'(new_tx_data), 0);
        chk("t4_rst_done", int'(block_done), 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("t4_no_resume", int'(new_tx_data | block_busy), 0);
        send_now(32'h01020304, 1'b1);
        wait_idle("t4");
        check_drained("t4");

        // 5: new block in the block_done cycle is accepted
        send_now(32'hCAFEF00D, 1'b1);
        n = 0;
        while (!block_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("t5_done_seen", int'(block_done), 1);
        send_now(32'h0BADBEEF, 1'b1);
        chk("t5_busy_again", int'(block_busy), 1);
        wait_idle("t5");
        check_drained("t5");

        // Random blocks with varying transmitter latency and spurious requests
        for (int k = 0; k < 16; k++) begin
            bmax = $urandom_range(1, 10);
            d = {$urandom()};
            send_now(d, 1'b1);
            repeat ($urandom_range(0, 8)) @(negedge clk);
            if (block_busy) send_now({$urandom()}, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                hold_busy = 1'b1;
                repeat ($urandom_range(1, 20)) @(negedge clk);
                hold_busy = 1'b0;
            end
            wait_idle("rnd");
        end
        check_drained("rnd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
